// File: rtl/sar_bs_multi.sv
// sar_bs_multi: multi-channel successive-approximation binary search controller
module sar_bs_multi #(
  parameter int NOB = 8,
  parameter int NCH = 4,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          scan,
  input  logic [CW-1:0] ch_sel,
  input  logic [1:0]    cmp,
  input  logic          cmp_vld,
  output logic          sample,
  output logic [CW-1:0] ch,
  output logic [NOB-1:0] value,
  output logic          busy,
  output logic          valid,
  output logic [NOB-1:0] result,
  output logic [CW-1:0] result_ch,
  output logic          exact,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, SAMPLE, SEARCH, DONE} state_t;
  localparam logic [CW-1:0] CMAX = CW'(NCH - 1);
  localparam logic [NOB-1:0] INIT = {1'b0, {(NOB-1){1'b1}}};
  state_t state, nxt;
  logic scan_r, term, more;
  logic [NOB-1:0] first, last, lo, hi, mid;
  // A search ends on an equal verdict or when the bracket cannot shrink further
  assign term = cmp_vld && (cmp[1] || (cmp[0] ? value == last : value == first));
  assign lo = (cmp == 2'b01) ? value + 1'b1 : first;
  assign hi = (cmp == 2'b00) ? value - 1'b1 : last;
  assign mid = lo + ((hi - lo) >> 1);
  assign more = scan_r && (ch < CMAX);
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // Next state and per-state strobes
  always_comb begin
    nxt = state;
    sample = 1'b0;
    busy = 1'b1;
    valid = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        nxt = start ? SAMPLE : IDLE;
      end
      SAMPLE: begin
        sample = 1'b1;
        nxt = SEARCH;
      end
      SEARCH: nxt = term ? DONE : SEARCH;
      DONE: begin
        valid = 1'b1;
        done = !more;
        nxt = more ? SAMPLE : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  // Search bracket, channel and result registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ch <= '0;
      scan_r <= 1'b0;
      first <= '0;
      last <= '1;
      value <= '0;
      result <= '0;
      result_ch <= '0;
      exact <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          ch <= scan ? '0 : (int'(ch_sel) > NCH - 1 ? CMAX : ch_sel);
          scan_r <= scan;
          first <= '0;
          last <= '1;
          value <= INIT;
        end
        SEARCH: if (term) begin
          result <= value;
          result_ch <= ch;
          exact <= cmp[1];
        end else if (cmp_vld) begin
          first <= lo;
          last <= hi;
          value <= mid;
        end
        DONE: if (more) begin
          ch <= ch + 1'b1;
          first <= '0;
          last <= '1;
          value <= INIT;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sar_bs_multi.sv
// tb_sar_bs_multi: randomized self-checking bench for sar_bs_multi against an ideal comparator model
module tb_sar_bs_multi;
  localparam int NOB = 8;
  localparam int NCH = 4;
  localparam int CW = 2;
  logic clk = 0, rst = 1, start = 0, scan = 0, cmp_vld = 0;
  logic [CW-1:0] ch_sel = '0;
  logic [1:0] cmp = '0;
  logic sample, busy, valid, exact, done;
  logic [CW-1:0] ch, result_ch;
  logic [NOB-1:0] value, result;
  int total = 0, bad = 0;
  int vin[NCH];
  int seq[$];
  int ncmp, nval, nsmp;

  sar_bs_multi #(.NOB(NOB), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .start(start), .scan(scan), .ch_sel(ch_sel),
    .cmp(cmp), .cmp_vld(cmp_vld), .sample(sample), .ch(ch), .value(value),
    .busy(busy), .valid(valid), .result(result), .result_ch(result_ch),
    .exact(exact), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Ideal comparator: mode 0 truthful against x, mode 1 always below, mode 2 always above
  function automatic logic [1:0] verdict(input int mode, input int v, input int x);
    return mode == 1 ? 2'b01 : mode == 2 ? 2'b00 :
           v == x ? {1'b1, 1'($urandom)} : v > x ? 2'b00 : 2'b01;
  endfunction

  task automatic check_seq(input int e[$]);
    check("seq_len", seq.size(), e.size());
    for (int i = 0; i < e.size() && i < seq.size(); i++) check("seq", seq[i], e[i]);
  endtask

  task automatic run_req(input logic sc, input logic [CW-1:0] cs, input int mode, input int vpct, input int gap);
    int exp_ch, cyc, lo_b, hi_b, v, g;
    logic fin, prev_hold, lst;
    logic [NOB-1:0] prev_v;
    @(negedge clk);
    start = 1; scan = sc; ch_sel = cs;
    @(negedge clk);
    start = 0;
    exp_ch = sc ? 0 : int'(cs);
    fin = 0; cyc = 0; nval = 0; nsmp = 0; ncmp = 0; g = gap;
    lo_b = -1; hi_b = 1 << NOB; prev_hold = 0; prev_v = '0;
    while (!fin && cyc < 3000) begin
      cyc++;
      v = int'(value);
      if (sample) begin
        check("sample_value", value, 127);
        check("sample_ch", ch, exp_ch);
        nsmp++; ncmp = 0; seq.delete();
        lo_b = -1; hi_b = 1 << NOB; prev_hold = 0;
        cmp_vld = 1'($urandom); cmp = 2'($urandom);
      end else if (valid) begin
        check("result", result, mode == 0 ? vin[exp_ch] : mode == 1 ? 255 : 0);
        check("exact", exact, mode == 0);
        check("result_ch", result_ch, exp_ch);
        check("ncmp_bound", ncmp <= NOB + 1, 1);
        nval++;
        lst = !sc || exp_ch == NCH - 1;
        check("done", done, lst);
        fin = lst; exp_ch++;
        start = 0; cmp_vld = 1'($urandom); cmp = 2'($urandom);
      end else if (busy) begin
        if (prev_hold) check("hold", value, prev_v);
        check("bracket", v > lo_b && v < hi_b, 1);
        if (ncmp == 2 && g > 0) begin
          cmp_vld = 0; g--;
        end else cmp_vld = ($urandom % 100) < vpct;
        cmp = verdict(mode, v, vin[exp_ch]);
        if (cmp_vld) begin
          ncmp++; seq.push_back(v);
          if (cmp == 2'b00) hi_b = v;
          else if (cmp == 2'b01) lo_b = v;
        end
        prev_hold = !cmp_vld; prev_v = value;
        start = ($urandom % 6) == 0; scan = 1'($urandom); ch_sel = CW'($urandom);
      end else begin
        check("early_idle", busy, 1);
        fin = 1;
      end
      @(negedge clk);
    end
    start = 0; cmp_vld = 0;
    if (!fin) check("timeout", 0, 1);
    check("idle_after", busy, 0);
  endtask

  initial begin
    int e[$];
    for (int i = 0; i < NCH; i++) vin[i] = 0;
    #2 rst = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_value", value, 0);
    check("rst_result", result, 0);
    check("rst_valid", valid, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    vin[2] = 200;
    run_req(0, 2, 0, 100, 0);
    e = '{127, 191, 223, 207, 199, 203, 201, 200};
    check_seq(e);
    run_req(0, 1, 1, 100, 0);
    check("ncmp9", ncmp, 9);
    e = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    check_seq(e);
    run_req(0, 3, 2, 100, 0);
    e = '{127, 63, 31, 15, 7, 3, 1, 0};
    check_seq(e);
    @(negedge clk);
    check("result_held", result, 0);
    for (int i = 0; i < NCH; i++) vin[i] = $urandom_range(0, 255);
    run_req(1, 2, 0, 100, 0);
    check("scan_valids", nval, 4);
    check("scan_samples", nsmp, 4);
    vin[1] = 77;
    run_req(0, 1, 0, 100, 5);
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < NCH; i++) vin[i] = $urandom_range(0, 255);
      run_req(1'($urandom), CW'($urandom), 0, $urandom_range(30, 100), $urandom_range(0, 3));
    end
    @(negedge clk);
    start = 1; scan = 0; ch_sel = 1;
    @(negedge clk);
    start = 0;
    repeat (3) begin
      @(negedge clk);
      cmp_vld = 1; cmp = 2'b01;
    end
    #2 rst = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_value", value, 0);
    check("arst_ch", ch, 0);
    check("arst_result", result, 0);
    check("arst_exact", exact, 0);
    check("arst_strobes", {sample, valid, done}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    begin
      logic any;
      any = 0;
      repeat (5) begin
        @(negedge clk);
        any = any | valid | busy;
      end
      check("no_pulse_after_rst", any, 0);
    end
    cmp_vld = 0;
    vin[0] = 5;
    run_req(0, 0, 0, 100, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sar_bs_multi.md
SAR_BS_MULTI -- requirements
Module: sar_bs_multi

Interface
REQ-001 Parameter NOB, default 8, SHALL set the code width in bits (NOB >= 2).
REQ-002 Parameter NCH, default 4, SHALL set the channel count (NCH >= 1).
REQ-003 Derived CW = max(1, clog2(NCH)) SHALL set the channel-index width.
REQ-004 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 start  input  1  SHALL request a conversion and is sampled only in IDLE.
REQ-007 scan  input  1  SHALL select the mode, sampled with start: 0 = single channel ch_sel; 1 = channels 0..NCH-1 in order.
REQ-008 ch_sel  input  CW  SHALL give the channel for a single conversion.
REQ-009 cmp  input  2  SHALL give the comparator verdict: 00 = value above input; 01 = value below input; 1x = equal.
REQ-010 cmp_vld  input  1  SHALL qualify cmp; cmp is ignored when cmp_vld=0.
REQ-011 sample  output  1  SHALL be high for one cycle in SAMPLE.
REQ-012 ch  output  CW  SHALL give the channel under conversion.
REQ-013 value  output  NOB  SHALL give the current trial DAC code.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.
REQ-015 valid  output  1  SHALL be a one-cycle pulse qualifying result, result_ch and exact.
REQ-016 result  output  NOB  SHALL hold the final code until the next valid.
REQ-017 result_ch  output  CW  SHALL hold the channel of the result.
REQ-018 exact  output  1  SHALL be 1 if the search ended on an equal verdict.
REQ-019 done  output  1  SHALL be a one-cycle pulse with the last valid of a request.

Function
REQ-020 The block SHALL implement the states IDLE, SAMPLE, SEARCH and DONE.
REQ-021 In IDLE with start=1, the next state SHALL be SAMPLE; ch = ch_sel if scan=0, else 0.
- Out-of-range ch_sel SHALL convert channel NCH-1.
REQ-022 On entry to SAMPLE, the block SHALL set first=0, last=2^NOB-1 and value=first+((last-first)>>1).
- This gives value=2^(NOB-1)-1.
REQ-023 SAMPLE SHALL last exactly one cycle and then go to SEARCH.
REQ-024 In SEARCH with cmp_vld=0, all registers SHALL hold.
REQ-025 In SEARCH with cmp_vld=1 and cmp=1x, the next state SHALL be DONE with result=value and exact=1.
REQ-026 cmp=00: if value==first, go to DONE with result=value and exact=0; else last=value-1 and value=new mid.
REQ-027 cmp=01: if value==last, go to DONE with result=value and exact=0; else first=value+1 and value=new mid.
REQ-028 Mid SHALL be computed as first+((last-first)>>1) with no overflow.
- last>=first SHALL always hold.
- A search SHALL take at most NOB+1 qualified compares.
REQ-029 DONE SHALL last one cycle and assert valid, with result_ch=ch.
REQ-030 From DONE: if scan mode and ch<NCH-1, ch SHALL increment and the next state SHALL be SAMPLE; otherwise the next state SHALL be IDLE with done=1 in DONE.
REQ-031 start SHALL be ignored while busy=1; a new request SHALL never abort one in progress.
REQ-032 cmp and cmp_vld SHALL be ignored outside SEARCH.
REQ-033 Latency: start at cycle t, SAMPLE at t+1, first compare accepted at t+2 or later, valid one cycle after the terminating compare.

Reset
REQ-034 rst=0 SHALL force, at any time and mid-operation, state=IDLE with all outputs and first set to 0 and last set to all-ones.
- No valid or done pulse SHALL be produced for an aborted conversion.
REQ-035 After rst is released, the first action SHALL be a new start in IDLE.

Verification
REQ-036 NOB=8, single mode, input 200, cmp_vld=1 every cycle: values 127,191,223,207,199,203,201,200 -> valid with result=200, exact=1.
REQ-037 cmp=01 always: values 127,191,223,239,247,251,253,254,255 -> result=255, exact=0, 9 compares.
REQ-038 cmp=00 always: values 127,63,31,15,7,3,1,0 -> result=0, exact=0.
REQ-039 NCH=4, scan=1, with equal verdicts: four valid pulses, result_ch 0,1,2,3, a sample pulse before each, and done only with the 4th.
REQ-040 start pulsed during SEARCH, and cmp_vld=0 for 5 cycles: no restart and value held, then the search resumes.
REQ-041 rst asserted mid-SEARCH: immediately idle with zero outputs; a following start gives a clean conversion.
